// File: rtl/discovery_reply_tx.sv
// HPSDR discovery reply transmitter: accepts the synchronised discovery request with a
// four-phase ACK, then streams the fixed reply payload byte-wise to the UDP transmit arbiter.
module discovery_reply_tx #(
  parameter int unsigned PAYLOAD_LEN   = 60,
  parameter logic [7:0]  CODE_VERSION  = 8'd13,
  parameter logic [7:0]  BOARD_ID      = 8'd1,
  parameter logic [15:0] GRANT_TIMEOUT = 16'd50000
) (
  input  logic        tx_clock,
  input  logic        reset_n,
  input  logic        discovery_reply,
  input  logic        run,
  input  logic [47:0] local_mac,
  input  logic        tx_grant,
  input  logic        tx_ready,
  output logic        discovery_ACK,
  output logic        sending_sync,
  output logic        tx_request,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic [15:0] tx_length
);

  typedef enum logic [1:0] {IDLE, REQ, SEND} main_state_t;
  typedef enum logic {ACK_IDLE, ACK_HIGH} ack_state_t;

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  main_state_t main_state_reg;
  ack_state_t  ack_state_reg;
  logic        req_meta_reg;
  logic        req_s;
  logic        run_reg;
  logic [47:0] mac_reg;
  logic [7:0]  byte_idx_reg;
  logic [15:0] timeout_cnt_reg;
  logic        start;
  logic [7:0]  idx_next;

  assign tx_length = 16'(PAYLOAD_LEN);
  assign idx_next  = byte_idx_reg + 8'd1;
  // A request is only taken when the previous one has been released and no reply is in flight.
  assign start     = (ack_state_reg == ACK_IDLE) && req_s && (main_state_reg == IDLE);

  function automatic logic [7:0] payload_byte(input logic [7:0] idx, input logic run_l,
                                              input logic [47:0] mac);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      8'd0:    b = 8'hEF;
      8'd1:    b = 8'hFE;
      8'd2:    b = run_l ? 8'h03 : 8'h02;
      8'd3:    b = mac[47:40];
      8'd4:    b = mac[39:32];
      8'd5:    b = mac[31:24];
      8'd6:    b = mac[23:16];
      8'd7:    b = mac[15:8];
      8'd8:    b = mac[7:0];
      8'd9:    b = CODE_VERSION;
      8'd10:   b = BOARD_ID;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_reg  <= 1'b0;
      req_s         <= 1'b0;
      ack_state_reg <= ACK_IDLE;
      discovery_ACK <= 1'b0;
      run_reg       <= 1'b0;
      mac_reg       <= 48'd0;
    end else begin
      req_meta_reg <= discovery_reply;
      req_s        <= req_meta_reg;
      case (ack_state_reg)
        ACK_IDLE: begin
          if (start) begin
            discovery_ACK <= 1'b1;
            run_reg       <= run;
            mac_reg       <= local_mac;
            ack_state_reg <= ACK_HIGH;
          end
        end
        ACK_HIGH: begin
          if (!req_s) begin
            discovery_ACK <= 1'b0;
            ack_state_reg <= ACK_IDLE;
          end
        end
        default: ack_state_reg <= ACK_IDLE;
      endcase
    end
  end

  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      main_state_reg  <= IDLE;
      sending_sync    <= 1'b0;
      tx_request      <= 1'b0;
      tx_valid        <= 1'b0;
      tx_data         <= 8'h00;
      tx_last         <= 1'b0;
      byte_idx_reg    <= 8'd0;
      timeout_cnt_reg <= 16'd0;
    end else begin
      case (main_state_reg)
        IDLE: begin
          if (start) begin
            main_state_reg  <= REQ;
            sending_sync    <= 1'b1;
            tx_request      <= 1'b1;
            timeout_cnt_reg <= 16'd0;
          end
        end
        REQ: begin
          if (tx_grant) begin
            main_state_reg <= SEND;
            byte_idx_reg   <= 8'd0;
            tx_valid       <= 1'b1;
            tx_data        <= payload_byte(8'd0, run_reg, mac_reg);
            tx_last        <= (LAST_IDX == 8'd0);
          end else if (timeout_cnt_reg == GRANT_TIMEOUT - 16'd1) begin
            main_state_reg <= IDLE;
            sending_sync   <= 1'b0;
            tx_request     <= 1'b0;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
          end
        end
        SEND: begin
          // Grant is deliberately not re-checked here; the arbiter holds it for the whole packet.
          if (tx_ready) begin
            if (tx_last) begin
              main_state_reg <= IDLE;
              tx_valid       <= 1'b0;
              tx_data        <= 8'h00;
              tx_last        <= 1'b0;
              tx_request     <= 1'b0;
              sending_sync   <= 1'b0;
            end else begin
              byte_idx_reg <= idx_next;
              tx_data      <= payload_byte(idx_next, run_reg, mac_reg);
              tx_last      <= (idx_next == LAST_IDX);
            end
          end
        end
        default: main_state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_discovery_reply_tx.sv
// Bench for discovery_reply_tx: expected payload beats are queued when a request is driven
// and consumed by a negedge monitor as the DUT hands bytes over.
module tb_discovery_reply_tx;
  localparam int LEN = 60;

  logic        tx_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        discovery_reply = 1'b0;
  logic        run = 1'b0;
  logic [47:0] local_mac = 48'd0;
  logic        tx_grant = 1'b1;
  logic        tx_ready = 1'b1;
  logic        discovery_ACK, sending_sync, tx_request, tx_valid, tx_last;
  logic [7:0]  tx_data;
  logic [15:0] tx_length;

  int n_cmp = 0;
  int n_fail = 0;
  int beats = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_word;
  logic       stall_prev = 1'b0;
  logic [8:0] stall_word = 9'd0;

  discovery_reply_tx #(
    .PAYLOAD_LEN(LEN), .CODE_VERSION(8'd13), .BOARD_ID(8'd1), .GRANT_TIMEOUT(16'd16)
  ) dut (
    .tx_clock(tx_clock), .reset_n(reset_n), .discovery_reply(discovery_reply), .run(run),
    .local_mac(local_mac), .tx_grant(tx_grant), .tx_ready(tx_ready),
    .discovery_ACK(discovery_ACK), .sending_sync(sending_sync), .tx_request(tx_request),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_length(tx_length)
  );

  always #5 tx_clock = ~tx_clock;

  // Scoreboard consumer: every handshake pops one expected {last,data} word.
  always @(negedge tx_clock) begin
    if (reset_n) begin
      if (stall_prev) begin
        n_cmp++;
        if (!tx_valid || {tx_last, tx_data} !== stall_word) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b last=%0b data=%02h, need valid=1 last=%0b data=%02h",
                   tx_valid, tx_last, tx_data, stall_word[8], stall_word[7:0]);
        end
      end
      if (tx_valid && tx_ready) begin
        beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got last=%0b data=%02h, need no beat", tx_last, tx_data);
        end else begin
          exp_word = exp_q.pop_front();
          if ({tx_last, tx_data} !== exp_word) begin
            n_fail++;
            $display("FAIL beat: got last=%0b data=%02h, need last=%0b data=%02h",
                     tx_last, tx_data, exp_word[8], exp_word[7:0]);
          end
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_word = {tx_last, tx_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_packet(input logic r, input logic [47:0] m);
    logic [7:0] b;
    for (int i = 0; i < LEN; i++) begin
      case (i)
        0: b = 8'hEF;
        1: b = 8'hFE;
        2: b = r ? 8'h03 : 8'h02;
        3: b = m[47:40];
        4: b = m[39:32];
        5: b = m[31:24];
        6: b = m[23:16];
        7: b = m[15:8];
        8: b = m[7:0];
        9: b = 8'h0D;
        10: b = 8'h01;
        default: b = 8'h00;
      endcase
      exp_q.push_back({(i == LEN - 1) ? 1'b1 : 1'b0, b});
    end
  endtask

  task automatic wait_ack(input logic level, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge tx_clock); #1;
      if (discovery_ACK === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge tx_clock); #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge tx_clock);
    #1;
    n_cmp++;
    if ({discovery_ACK, sending_sync, tx_request, tx_valid, tx_last, tx_data} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%0b sync=%0b req=%0b valid=%0b last=%0b data=%02h, need all 0",
               discovery_ACK, sending_sync, tx_request, tx_valid, tx_last, tx_data);
    end
    n_cmp++;
    if (tx_length !== 16'd60) begin
      n_fail++;
      $display("FAIL tx_length: got %0d, need 60", tx_length);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge tx_clock);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic ok;
    local_mac = 48'h00_1C_C0_A2_13_DD;
    run = 1'b0;
    push_packet(1'b0, 48'h00_1C_C0_A2_13_DD);
    @(posedge tx_clock); #1;
    discovery_reply = 1'b1;
    repeat (3) @(negedge tx_clock);
    #1;
    n_cmp++;
    if (discovery_ACK !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_early: got %0b after 2 cycles, need 0", discovery_ACK);
    end
    @(negedge tx_clock); #1;
    n_cmp++;
    if (discovery_ACK !== 1'b1 || sending_sync !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_latency: got ack=%0b sync=%0b after 3 cycles, need 1 1", discovery_ACK, sending_sync);
    end
    @(posedge tx_clock); #1;
    discovery_reply = 1'b0;
    wait_drain(300, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_drain: got %0d bytes outstanding, need 0", exp_q.size());
    end
    n_cmp++;
    if (sending_sync !== 1'b1 || tx_last !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_last_sync: got sync=%0b last=%0b on last byte, need 1 1", sending_sync, tx_last);
    end
    @(negedge tx_clock); #1;
    n_cmp++;
    if ({sending_sync, tx_request, tx_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_end: got sync=%0b req=%0b valid=%0b after last, need 0 0 0",
               sending_sync, tx_request, tx_valid);
    end
    wait_ack(1'b0, 20, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_ack_release: got ack=%0b, need 0", discovery_ACK);
    end
    $display("test_basic done, beats=%0d", beats);
  endtask

  task automatic test_run_flag();
    logic ok;
    run = 1'b1;
    local_mac = 48'hA1_B2_C3_D4_E5_F6;
    push_packet(1'b1, 48'hA1_B2_C3_D4_E5_F6);
    @(posedge tx_clock); #1;
    discovery_reply = 1'b1;
    wait_ack(1'b1, 20, ok);
    run = 1'b0;
    local_mac = 48'h11_22_33_44_55_66;
    discovery_reply = 1'b0;
    wait_drain(300, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL run_drain: got %0d bytes outstanding, need 0", exp_q.size());
    end
    wait_ack(1'b0, 20, ok);
    $display("test_run_flag done, beats=%0d", beats);
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    push_packet(1'b0, 48'h02_04_06_08_0A_0C);
    local_mac = 48'h02_04_06_08_0A_0C;
    @(posedge tx_clock); #1;
    discovery_reply = 1'b1;
    wait_ack(1'b1, 20, ok);
    discovery_reply = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge tx_clock); #1;
      tx_ready = pat[ph];
      ph = (ph + 1) % 4;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    tx_ready = 1'b1;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d bytes outstanding, need 0", exp_q.size());
    end
    wait_ack(1'b0, 20, ok);
    $display("test_backpressure done, beats=%0d", beats);
  endtask

  task automatic test_grant_timeout();
    logic ok;
    int hi;
    int saw_valid;
    hi = 0;
    saw_valid = 0;
    tx_grant = 1'b0;
    @(posedge tx_clock); #1;
    discovery_reply = 1'b1;
    wait_ack(1'b1, 20, ok);
    for (int i = 0; i < 100; i++) begin
      if (tx_valid) saw_valid++;
      if (!tx_request) break;
      hi++;
      @(negedge tx_clock); #1;
    end
    n_cmp++;
    if (hi != 16) begin
      n_fail++;
      $display("FAIL timeout_len: got tx_request high %0d cycles, need 16", hi);
    end
    n_cmp++;
    if (saw_valid != 0 || sending_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got valid_cycles=%0d sync=%0b, need 0 0", saw_valid, sending_sync);
    end
    repeat (5) @(negedge tx_clock);
    #1;
    n_cmp++;
    if (discovery_ACK !== 1'b1 || tx_request !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_ack_hold: got ack=%0b req=%0b, need 1 0", discovery_ACK, tx_request);
    end
    discovery_reply = 1'b0;
    wait_ack(1'b0, 20, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_ack_release: got ack=%0b, need 0", discovery_ACK);
    end
    tx_grant = 1'b1;
    $display("test_grant_timeout done, request cycles=%0d", hi);
  endtask

  task automatic test_rerequest();
    logic ok;
    local_mac = 48'hDE_AD_BE_EF_00_01;
    push_packet(1'b0, 48'hDE_AD_BE_EF_00_01);
    @(posedge tx_clock); #1;
    discovery_reply = 1'b1;
    repeat (200) @(negedge tx_clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || discovery_ACK !== 1'b1 || sending_sync !== 1'b0) begin
      n_fail++;
      $display("FAIL rereq_single: got outstanding=%0d ack=%0b sync=%0b, need 0 1 0",
               exp_q.size(), discovery_ACK, sending_sync);
    end
    discovery_reply = 1'b0;
    wait_ack(1'b0, 20, ok);
    push_packet(1'b0, 48'hDE_AD_BE_EF_00_01);
    discovery_reply = 1'b1;
    wait_ack(1'b1, 20, ok);
    discovery_reply = 1'b0;
    wait_drain(300, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rereq_second: got %0d bytes outstanding, need 0", exp_q.size());
    end
    wait_ack(1'b0, 20, ok);
    $display("test_rerequest done, beats=%0d", beats);
  endtask

  task automatic test_reset_midsend();
    logic ok;
    int base;
    local_mac = 48'h00_1C_C0_A2_13_DD;
    push_packet(1'b0, 48'h00_1C_C0_A2_13_DD);
    base = beats;
    @(posedge tx_clock); #1;
    discovery_reply = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tx_clock); #1;
      if (beats - base >= 20) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midsend_reach: got %0d beats, need 20", beats - base);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({discovery_ACK, sending_sync, tx_request, tx_valid, tx_last, tx_data} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset: got ack=%0b sync=%0b req=%0b valid=%0b last=%0b data=%02h, need all 0",
               discovery_ACK, sending_sync, tx_request, tx_valid, tx_last, tx_data);
    end
    exp_q.delete();
    discovery_reply = 1'b0;
    repeat (2) @(posedge tx_clock);
    #1;
    reset_n = 1'b1;
    push_packet(1'b0, 48'h00_1C_C0_A2_13_DD);
    @(posedge tx_clock); #1;
    discovery_reply = 1'b1;
    wait_ack(1'b1, 20, ok);
    discovery_reply = 1'b0;
    wait_drain(300, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL post_reset_packet: got %0d bytes outstanding, need 0", exp_q.size());
    end
    wait_ack(1'b0, 20, ok);
    $display("test_reset_midsend done, beats=%0d", beats);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_run_flag();
    test_backpressure();
    test_grant_timeout();
    test_rerequest();
    test_reset_midsend();
    repeat (5) @(negedge tx_clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/discovery_reply_tx.md
Name: discovery_reply_tx

Overview:
- Transmit-side counterpart of the port-1024 discovery command detector.
- Takes the `discovery_reply` request level from the receive path and returns `discovery_ACK` with a four-phase handshake.
- Builds the fixed-format HPSDR discovery reply UDP payload and streams it byte-wise to the UDP/IP transmit arbiter.
- Holds `sending_sync` high for the whole send, so the receiver stays in its wait state.

Parameters:
- PAYLOAD_LEN, 60: reply payload length in bytes; legal range 11..255.
- CODE_VERSION, 8'd13: firmware version byte placed at payload offset 9.
- BOARD_ID, 8'd1: board type byte placed at payload offset 10.
- GRANT_TIMEOUT, 16'd50000: maximum tx_clock cycles spent waiting for tx_grant before the reply is abandoned.

Ports:
- tx_clock  in  1  transmit clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- discovery_reply  in  1  request level from the rx_clock domain; synchronised internally with 2 FFs.
- run  in  1  radio streaming flag; sampled at request acceptance.
- local_mac  in  48  board MAC address; sampled at request acceptance.
- tx_grant  in  1  arbiter grant of the UDP transmit path.
- tx_ready  in  1  downstream accepts the current byte.
- discovery_ACK  out  1  acknowledge back to the request source.
- sending_sync  out  1  high while a reply is requested or in transmission.
- tx_request  out  1  request for the UDP transmit path.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  8  payload byte.
- tx_last  out  1  marks the final payload byte.
- tx_length  out  16  constant PAYLOAD_LEN, zero-extended.

Behaviour:
- Reset: every output is 0, except tx_length, which is constant. States go to IDLE/ACK_IDLE. The sync FFs, byte index and timeout counter clear. Reset asserted mid-send aborts immediately; no tx_last is issued.
- Request sync: req_s is the second FF of the synchroniser. Request-to-acceptance latency is 3 tx_clock cycles (2 sync + 1 registered state).

Handshake FSM (ACK_IDLE, ACK_HIGH):
- ACK_IDLE: when req_s=1 and the main FSM is IDLE:
  - set discovery_ACK=1;
  - latch run and local_mac;
  - pulse start;
  - go to ACK_HIGH.
- ACK_HIGH: hold discovery_ACK=1 until req_s=0, then clear it and return to ACK_IDLE.
- A new request is accepted only after req_s has been seen low. One request level therefore produces exactly one reply.
- If the source times out and drops the request, ACK still completes normally.

Main FSM (IDLE, REQ, SEND):
- IDLE: on start, go to REQ. Set sending_sync=1 and tx_request=1 from the next cycle. Clear the timeout counter.
- REQ:
  - If tx_grant=1: go to SEND with byte_idx=0.
  - Otherwise increment the counter. When it reaches GRANT_TIMEOUT-1, drop tx_request and sending_sync and return to IDLE. No bytes are sent.
- SEND:
  - tx_valid=1 and tx_data=byte(byte_idx).
  - byte_idx advances only when tx_valid && tx_ready.
  - tx_last=1 when byte_idx==PAYLOAD_LEN-1.
  - On the handshake of the last byte: tx_valid, tx_request and sending_sync drop on the next cycle; return to IDLE.
  - tx_grant dropping during SEND is ignored; the arbiter must not revoke a grant mid-packet.
  - tx_data, tx_valid and tx_last are stable while tx_ready=0.

Payload map (byte_idx is 8 bits, never wraps):
- 0: 0xEF
- 1: 0xFE
- 2: 0x03 if latched run=1, else 0x02
- 3..8: latched MAC, byte 3 = mac[47:40] down to byte 8 = mac[7:0]
- 9: CODE_VERSION
- 10: BOARD_ID
- 11..PAYLOAD_LEN-1: 0x00

Simultaneous and boundary events:
- A request arriving while the main FSM is not IDLE is held off (no ACK) until the send finishes. It is then served.
- run and local_mac changes after acceptance do not affect the packet in flight.
- Minimum packet duration is PAYLOAD_LEN cycles, with tx_ready held high.

Test Plan:
- Basic reply: local_mac=48'h00_1C_C0_A2_13_DD, run=0, PAYLOAD_LEN=60. Pulse discovery_reply high, tx_grant=1, tx_ready=1. Required:
  - discovery_ACK rises 3 cycles after discovery_reply;
  - exactly 60 bytes, starting EF FE 02 00 1C C0 A2 13 DD 0D 01, then 49×00;
  - tx_last on byte 60;
  - sending_sync high from REQ until the cycle after the last byte.
- Run flag: run=1 at acceptance, then run=0 mid-packet -> byte 2 = 0x03.
- Backpressure: tx_ready toggles 1,0,0,1 repeatedly -> data is held during stalls; still 60 beats with no duplicates or skips.
- Grant timeout: GRANT_TIMEOUT=16, tx_grant=0 -> tx_request and sending_sync drop after 16 cycles, no tx_valid, FSM returns to IDLE; ACK still follows the request level.
- Re-request: hold discovery_reply high across two packet durations -> exactly one packet. Drop it and raise it again -> a second packet.
- Reset: assert reset_n=0 at byte 20 -> all outputs 0 asynchronously. After release, a fresh request gives a complete 60-byte packet.
